sram_bus_arbiter: RTL and testbench

- Shares one downstream SRAM-style line bus (feeding mem2axi) between NUM_M upstream masters: icache refill, dcache refill/write-back, and LSU uncached access.
- Each master presents a read-request channel, a write-request channel and a read-response channel.
- The arbiter serialises whole transactions, one outstanding at a time, with round-robin fairness.
- A granted master with both read and write pending issues its write first, so a dirty write-back precedes its refill.

---
 rtl/sram_bus_arbiter_pkg.sv | 25 ++
 rtl/sram_bus_arbiter_rr_pick.sv | 53 +++++
 rtl/sram_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared widths, arbiter state encoding and packed-bus slice helper for sram_bus_arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef SRAM_BUS_PKG_SV
`define SRAM_BUS_PKG_SV

// Select the slice of a packed per-master bus belonging to master idx.
`define SRAM_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package sram_bus_pkg;

    localparam int AW = 32;   // address width
    localparam int LW = 256;  // line data width
    localparam int TW = 6;    // transfer-type width
    localparam int SW = 16;   // write-strobe width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } arb_state_e;

endpackage

`endif

// File: rtl/sram_bus_arbiter_rr_pick.sv
// Picks one pending master: first set bit at/after ptr (wrapping), or lowest index under SRAM_ARB_FIXED_PRIO_EN.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  pend,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Pointer is held at zero by the caller and plays no part in a fixed-priority pick.
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Priority encoder: lowest pending index wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && pend[PW'(k)]) begin
                any              = 1'b1;
                gnt_oh[PW'(k)]   = 1'b1;
                gnt_idx          = PW'(k);
            end
        end
    end
`else
    // Rotating search: scan N slots starting at ptr, first pending slot wins.
    always_comb begin
        int j;
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && pend[PW'(j)]) begin
                any              = 1'b1;
                gnt_oh[PW'(j)]   = 1'b1;
                gnt_idx          = PW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM line bus among NUM_M masters, one whole transaction at a time, write before read (SRAM_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: 1 cycle arbitration + 1 issue cycle minimum; read data and its valid pass through combinationally.
// Backpressure: downstream s_*_rdy is forwarded to the granted master's rdy; ISSUE holds until the handshake.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int NUM_M = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    m_r_req,
    input  logic [NUM_M*AW-1:0] m_r_addr,
    input  logic [NUM_M*TW-1:0] m_r_type,
    output logic [NUM_M-1:0]    m_r_rdy,
    output logic [LW-1:0]       m_re_data,
    output logic [NUM_M-1:0]    m_re_valid,
    input  logic [NUM_M-1:0]    m_w_req,
    input  logic [NUM_M*AW-1:0] m_w_addr,
    input  logic [NUM_M*LW-1:0] m_w_data,
    input  logic [NUM_M*TW-1:0] m_w_type,
    input  logic [NUM_M*SW-1:0] m_w_strb,
    output logic [NUM_M-1:0]    m_w_rdy,
    output logic                s_r_req,
    output logic [AW-1:0]       s_r_addr,
    output logic [TW-1:0]       s_r_type,
    input  logic                s_r_rdy,
    input  logic [LW-1:0]       s_re_data,
    input  logic                s_re_valid,
    output logic                s_w_req,
    output logic [AW-1:0]       s_w_addr,
    output logic [LW-1:0]       s_w_data,
    output logic [TW-1:0]       s_w_type,
    output logic [SW-1:0]       s_w_strb,
    input  logic                s_w_rdy
);

    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [NUM_M-1:0] grant_oh_q, grant_oh_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    ptr_after;

    logic [NUM_M-1:0] pend;
    logic [NUM_M-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic             w_sel, r_sel;

    logic [AW-1:0] r_addr_a [NUM_M];
    logic [TW-1:0] r_type_a [NUM_M];
    logic [AW-1:0] w_addr_a [NUM_M];
    logic [LW-1:0] w_data_a [NUM_M];
    logic [TW-1:0] w_type_a [NUM_M];
    logic [SW-1:0] w_strb_a [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_slice
        assign r_addr_a[i] = `SRAM_SLICE(m_r_addr, i, AW);
        assign r_type_a[i] = `SRAM_SLICE(m_r_type, i, TW);
        assign w_addr_a[i] = `SRAM_SLICE(m_w_addr, i, AW);
        assign w_data_a[i] = `SRAM_SLICE(m_w_data, i, LW);
        assign w_type_a[i] = `SRAM_SLICE(m_w_type, i, TW);
        assign w_strb_a[i] = `SRAM_SLICE(m_w_strb, i, SW);
    end

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(NUM_M - 1)) return '0;
        return v + PW'(1);
    endfunction

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign ptr_after = '0;
`else
    assign ptr_after = wrap_inc(grant_q);
`endif

    assign pend      = m_r_req | m_w_req;
    assign w_sel     = |(m_w_req & grant_oh_q);
    assign r_sel     = |(m_r_req & grant_oh_q);
    // Read line is broadcast unregistered; only the valid pulse selects the owner.
    assign m_re_data = s_re_data;

    rr_pick #(.N(NUM_M), .PW(PW)) u_rr_pick (
        .pend    (pend),
        .ptr     (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // State, grant and fairness pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Next-state and per-state bus steering; everything idles at zero by default.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        m_r_rdy    = '0;
        m_w_rdy    = '0;
        m_re_valid = '0;
        s_r_req    = 1'b0;
        s_r_addr   = '0;
        s_r_type   = '0;
        s_w_req    = 1'b0;
        s_w_addr   = '0;
        s_w_data   = '0;
        s_w_type   = '0;
        s_w_strb   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (w_sel) begin
                    // Write goes first so a dirty victim lands before its refill.
                    s_w_req  = 1'b1;
                    s_w_addr = w_addr_a[grant_q];
                    s_w_data = w_data_a[grant_q];
                    s_w_type = w_type_a[grant_q];
                    s_w_strb = w_strb_a[grant_q];
                    m_w_rdy  = grant_oh_q & {NUM_M{s_w_rdy}};
                    if (s_w_rdy) begin
                        state_d  = IDLE;
                        rr_ptr_d = ptr_after;
                    end
                end else if (r_sel) begin
                    s_r_req  = 1'b1;
                    s_r_addr = r_addr_a[grant_q];
                    s_r_type = r_type_a[grant_q];
                    m_r_rdy  = grant_oh_q & {NUM_M{s_r_rdy}};
                    if (s_r_rdy) state_d = RWAIT;
                end else begin
                    // Master withdrew before the handshake: give up the slot without moving fairness.
                    state_d = IDLE;
                end
            end
            RWAIT: begin
                if (s_re_valid) begin
                    m_re_valid = grant_oh_q;
                    state_d    = IDLE;
                    rr_ptr_d   = ptr_after;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed and randomized checks of sram_bus_arbiter against a transaction-level fairness model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: downstream ready randomly deasserted in the random phase.
module tb_sram_bus_arbiter;
    import sram_bus_pkg::*;

    localparam int NM = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM-1:0]    m_r_req, m_r_rdy, m_re_valid, m_w_req, m_w_rdy;
    logic [NM*AW-1:0] m_r_addr, m_w_addr;
    logic [NM*TW-1:0] m_r_type, m_w_type;
    logic [NM*LW-1:0] m_w_data;
    logic [NM*SW-1:0] m_w_strb;
    logic [LW-1:0]    m_re_data, s_re_data, s_w_data;
    logic             s_r_req, s_r_rdy, s_re_valid, s_w_req, s_w_rdy;
    logic [AW-1:0]    s_r_addr, s_w_addr;
    logic [TW-1:0]    s_r_type, s_w_type;
    logic [SW-1:0]    s_w_strb;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.NUM_M(NM)) dut (
        .clk(clk), .rst(rst),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy),
        .m_re_data(m_re_data), .m_re_valid(m_re_valid),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
        .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy),
        .s_r_req(s_r_req), .s_r_addr(s_r_addr), .s_r_type(s_r_type), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(s_w_req), .s_w_addr(s_w_addr), .s_w_data(s_w_data), .s_w_type(s_w_type),
        .s_w_strb(s_w_strb), .s_w_rdy(s_w_rdy)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
        logic [TW-1:0] t;
        logic [SW-1:0] s;
    } txn_t;

    txn_t q [NM][$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NM-1:0] oh(input int i);
        logic [NM-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Transaction-level arbitration rule: next master with queued work after the last one served.
    function automatic int exp_master(input int last);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NM; i++) if (q[i].size() > 0) return i;
`else
        for (int k = 1; k <= NM; k++) if (q[(last + k) % NM].size() > 0) return (last + k) % NM;
`endif
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_r(input int i, input logic req, input logic [AW-1:0] a, input logic [TW-1:0] t);
        m_r_req[i]         = req;
        m_r_addr[i*AW +: AW] = a;
        m_r_type[i*TW +: TW] = t;
    endtask

    task automatic drv_w(input int i, input logic req, input logic [AW-1:0] a, input logic [LW-1:0] d,
                         input logic [TW-1:0] t, input logic [SW-1:0] s);
        m_w_req[i]           = req;
        m_w_addr[i*AW +: AW] = a;
        m_w_data[i*LW +: LW] = d;
        m_w_type[i*TW +: TW] = t;
        m_w_strb[i*SW +: SW] = s;
    endtask

    task automatic idle_inputs();
        m_r_req = '0; m_r_addr = '0; m_r_type = '0;
        m_w_req = '0; m_w_addr = '0; m_w_data = '0; m_w_type = '0; m_w_strb = '0;
        s_r_rdy = 1'b0; s_w_rdy = 1'b0; s_re_valid = 1'b0; s_re_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] line, rdata;
        logic [NM-1:0] all_req;
        int   cnt, n_acc, n_done, own, last, lastdone, owner, rcnt, e, left;
        bit   busy, gap_chk, rbusy;
        bit   waiting [NM];
        txn_t h, t;

        // Reset state.
        do_reset();
        #1;
        chk("reset_ctl", {s_r_req, s_w_req, m_r_rdy, m_w_rdy, m_re_valid}, '0);
        chk("reset_addr", {s_r_addr, s_w_addr, s_w_strb}, '0);

        // Single read from master 1, data 5 cycles after accept.
        drv_r(1, 1'b1, 32'h8000_0040, 6'h2); s_r_rdy = 1'b1; #1;
        chk("t1_idle_no_req", s_r_req, 0);
        step(); #1;
        chk("t1_s_r_req", s_r_req, 1);
        chk("t1_s_r_addr", s_r_addr, 32'h8000_0040);
        chk("t1_s_r_type", s_r_type, 6'h2);
        chk("t1_m_r_rdy", m_r_rdy, 3'b010);
        for (int c = 0; c < 4; c++) begin
            step(); drv_r(1, 1'b0, '0, '0); s_r_rdy = 1'b0; #1;
            chk("t1_wait_quiet", {s_r_req, m_re_valid}, '0);
        end
        line = {8{32'hCAFE_0001}};
        step(); s_re_valid = 1'b1; s_re_data = line; #1;
        chk("t1_m_re_valid", m_re_valid, 3'b010);
        chk("t1_m_re_data", m_re_data, line);
        step(); s_re_valid = 1'b0; #1;
        chk("t1_valid_one_cycle", m_re_valid, 0);

        // Write-before-read on master 1.
        line = {8{32'h5A5A_0100}};
        drv_w(1, 1'b1, 32'h100, line, 6'h3, 16'hF0F0);
        drv_r(1, 1'b1, 32'h200, 6'h4);
        s_w_rdy = 1'b1; s_r_rdy = 1'b1; #1;
        chk("t2_idle", {s_w_req, s_r_req}, 0);
        step(); #1;
        chk("t2_s_w_req", s_w_req, 1);
        chk("t2_s_w_addr", s_w_addr, 32'h100);
        chk("t2_s_w_data", s_w_data, line);
        chk("t2_s_w_strb", s_w_strb, 16'hF0F0);
        chk("t2_m_w_rdy", m_w_rdy, 3'b010);
        chk("t2_no_read_yet", {s_r_req, m_r_rdy}, 0);
        step(); drv_w(1, 1'b0, '0, '0, '0, '0); #1;
        chk("t2_rearb_idle", {s_w_req, s_r_req}, 0);
        step(); #1;
        chk("t2_s_r_addr", {s_r_req, s_r_addr}, {1'b1, 32'h200});
        chk("t2_m_r_rdy", m_r_rdy, 3'b010);
        step(); drv_r(1, 1'b0, '0, '0); s_re_valid = 1'b1; s_re_data = {8{32'h0BAD_F00D}}; #1;
        chk("t2_m_re_valid", m_re_valid, 3'b010);
        step(); s_re_valid = 1'b0;

        // Fairness: all three masters hold read requests; response 2 cycles after accept.
        do_reset();
        for (int i = 0; i < NM; i++) drv_r(i, 1'b0, 32'h1000 * (i + 1), TW'(i));
        cnt = 0; n_acc = 0; n_done = 0; own = 0; busy = 0;
        for (int c = 0; c < 200 && n_done < 6; c++) begin
            all_req = (n_acc < 6) ? '1 : '0;
            m_r_req = all_req;
            s_r_rdy = 1'b1;
            if (busy && cnt > 0) cnt--;
            s_re_valid = busy && (cnt == 0);
            s_re_data  = {8{32'(c)}};
            #1;
            if (s_re_valid) begin
                chk("t3_rvalid_owner", m_re_valid, oh(own));
                busy = 0;
                n_done++;
            end
            if (s_r_req && s_r_rdy) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                own = 0;
`else
                own = n_acc % NM;
`endif
                chk($sformatf("t3_grant%0d", n_acc), m_r_rdy, oh(own));
                busy = 1; cnt = 2; n_acc++;
            end
            step();
        end
        s_re_valid = 1'b0; m_r_req = '0;
        chk("t3_six_done", n_done, 6);

        // Abort: master 0 withdraws while stalled; master 2 is served next.
        step();
        drv_r(0, 1'b1, 32'hA0, 6'h1); s_r_rdy = 1'b0; #1;
        chk("t4_idle", s_r_req, 0);
        step(); drv_r(2, 1'b1, 32'hC0, 6'h5); #1;
        chk("t4_issue0", {s_r_req, s_r_addr, m_r_rdy}, {1'b1, 32'hA0, 3'b000});
        step(); drv_r(0, 1'b0, '0, '0); #1;
        chk("t4_withdrawn", {s_r_req, m_r_rdy}, 0);
        step(); s_r_rdy = 1'b1; #1;
        chk("t4_back_idle", s_r_req, 0);
        step(); #1;
        chk("t4_issue2", {s_r_req, s_r_addr, m_r_rdy}, {1'b1, 32'hC0, 3'b100});
        step(); drv_r(2, 1'b0, '0, '0); s_re_valid = 1'b1; #1;
        chk("t4_m_re_valid", m_re_valid, 3'b100);
        step(); s_re_valid = 1'b0;

        // Reset while waiting for read data.
        drv_r(1, 1'b1, 32'h300, 6'h0); s_r_rdy = 1'b1; #1;
        step(); #1;
        chk("t5_issue", s_r_req, 1);
        step(); drv_r(1, 1'b0, '0, '0); rst = 1'b1; #1;
        step(); rst = 1'b0; #1;
        chk("t5_outputs_zero", {s_r_req, s_w_req, m_r_rdy, m_w_rdy, m_re_valid}, '0);
        s_re_valid = 1'b1; s_re_data = {8{32'h1234_5678}}; #1;
        chk("t5_stale_valid_dropped", m_re_valid, 0);
        step(); s_re_valid = 1'b0; #1;
        chk("t5_still_idle", {s_r_req, s_w_req}, 0);

        // Randomized traffic: each master works through its own queue of reads and writes.
        do_reset();
        for (int i = 0; i < NM; i++) begin
            waiting[i] = 0;
            for (int n = 0; n < 6; n++) begin
                t.wr = 1'($urandom_range(0, 1));
                t.a  = $urandom;
                t.d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                t.t  = TW'($urandom);
                t.s  = SW'($urandom);
                q[i].push_back(t);
            end
        end
        last = NM - 1; lastdone = 0; gap_chk = 0; owner = 0; rcnt = 0; rbusy = 0; rdata = '0;
        for (int c = 0; c < 3000; c++) begin
            if (q[0].size() + q[1].size() + q[2].size() == 0 && !rbusy) break;
            for (int i = 0; i < NM; i++) begin
                drv_r(i, 1'b0, '0, '0);
                drv_w(i, 1'b0, '0, '0, '0, '0);
                if (q[i].size() > 0 && !waiting[i]) begin
                    h = q[i][0];
                    if (h.wr) drv_w(i, 1'b1, h.a, h.d, h.t, h.s);
                    else      drv_r(i, 1'b1, h.a, h.t);
                end
            end
            s_w_rdy = ($urandom_range(0, 3) != 0);
            s_r_rdy = ($urandom_range(0, 3) != 0);
            if (rbusy && rcnt > 0) rcnt--;
            s_re_valid = rbusy && (rcnt == 0);
            rdata      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            s_re_data  = rdata;
            #1;
            if (gap_chk && (s_w_req || s_r_req)) begin
                chk("rnd_rearb_gap", c - lastdone, 2);
                gap_chk = 0;
            end
            if (s_w_req && s_w_rdy) begin
                e = exp_master(last);
                if (e < 0) chk("rnd_spurious_w", 1, 0);
                else begin
                    h = q[e].pop_front();
                    chk("rnd_w_owner", m_w_rdy, oh(e));
                    chk("rnd_w_kind", h.wr, 1);
                    chk("rnd_w_addr", s_w_addr, h.a);
                    chk("rnd_w_data", s_w_data, h.d);
                    chk("rnd_w_type_strb", {s_w_type, s_w_strb}, {h.t, h.s});
                    last = e; lastdone = c; gap_chk = 1;
                end
            end
            if (s_r_req && s_r_rdy) begin
                e = exp_master(last);
                if (e < 0) chk("rnd_spurious_r", 1, 0);
                else begin
                    h = q[e].pop_front();
                    chk("rnd_r_owner", m_r_rdy, oh(e));
                    chk("rnd_r_kind", h.wr, 0);
                    chk("rnd_r_addr_type", {s_r_addr, s_r_type}, {h.a, h.t});
                    waiting[e] = 1; owner = e; rbusy = 1;
                    rcnt = $urandom_range(1, 4);
                end
            end
            if (s_re_valid) begin
                chk("rnd_rvalid", m_re_valid, oh(owner));
                chk("rnd_rdata", m_re_data, rdata);
                waiting[owner] = 0; rbusy = 0;
                last = owner; lastdone = c; gap_chk = 1;
            end else begin
                chk("rnd_no_rvalid", m_re_valid, 0);
            end
            step();
        end
        left = q[0].size() + q[1].size() + q[2].size() + int'(rbusy);
        chk("rnd_drained", left, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
